// File: rtl/riscv_pkg.sv
// Shared RISC-V control constants: opcodes, funct3 values, ALU operations,
// datapath mux selects and the multicycle controller state encoding.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [2:0] ALU_ADD     = 3'b000;
  localparam logic [2:0] ALU_SUB     = 3'b001;
  localparam logic [2:0] ALU_RTYPE   = 3'b010;
  localparam logic [2:0] ALU_CMP     = 3'b100;
  localparam logic [2:0] ALU_SPECIAL = 3'b111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] IMM_I  = 2'b00;
  localparam logic [1:0] IMM_S  = 2'b01;
  localparam logic [1:0] IMM_B  = 2'b10;
  localparam logic [1:0] IMM_JU = 2'b11;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXEC_R   = 4'd6;
  localparam logic [3:0] S_EXEC_I   = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_LUI      = 4'd11;
  localparam logic [3:0] S_TRAP     = 4'd12;
  // Never a real state; decodes to all-zero outputs.
  localparam logic [3:0] S_IDLE     = 4'd15;

  function automatic logic is_mem_op(input logic [6:0] opcode);
    return (opcode == OP_LOAD) || (opcode == OP_STORE);
  endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Per-state control output decode for the multicycle controller.
// Pure combinational function of state and funct3.
module mc_output_decode
  import riscv_pkg::*;
(
  input  logic [3:0] state,
  input  logic [2:0] funct3,
  output logic       mem_req,
  output logic       pc_write,
  output logic       branch,
  output logic       adr_src,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] imm_src,
  output logic [2:0] alu_op
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    mem_req    = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    result_src = RES_ALUOUT;
    imm_src    = IMM_I;
    alu_op     = ALU_ADD;
    case (state)
      S_FETCH: begin
        // pc_write/ir_write are qualified with mem_ready by the parent.
        mem_req    = 1'b1;
        pc_write   = 1'b1;
        ir_write   = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_B;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        result_src = RES_MEM;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALU_RTYPE;
      end
      S_EXEC_I: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_SPECIAL;
      end
      S_ALUWB: reg_write = 1'b1;
      S_BRANCH: begin
        branch    = 1'b1;
        alu_src_a = SRCA_RS1;
        alu_op    = (funct3 == F3_BNE) ? ALU_CMP : ALU_SUB;
      end
      S_JAL: begin
        pc_write  = 1'b1;
        reg_write = 1'b1;
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        imm_src   = IMM_JU;
      end
      S_LUI: begin
        reg_write = 1'b1;
        imm_src   = IMM_JU;
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM: state register, next-state logic and the
// sticky illegal-opcode flag; output decode lives in mc_output_decode.
module multicycle_controller
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       PCWrite,
  output logic       Branch,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALU_op,
  output logic       illegal
);

  logic [3:0] state;
  logic [3:0] next_state;
  logic [3:0] dec_state;
  logic       active;
  logic       illegal_q;
  logic       ready;
  logic       dec_pc_write;
  logic       dec_ir_write;
  logic [1:0] dec_imm_src;

  // The cycle after a reset edge is quiet: FETCH with every output held low.
  assign dec_state = active ? state : S_IDLE;
  assign ready     = mem_ready & mem_req;

  mc_output_decode u_decode (
    .state      (dec_state),
    .funct3     (funct3),
    .mem_req    (mem_req),
    .pc_write   (dec_pc_write),
    .branch     (Branch),
    .adr_src    (AdrSrc),
    .ir_write   (dec_ir_write),
    .mem_write  (MemWrite),
    .reg_write  (RegWrite),
    .alu_src_a  (ALUSrcA),
    .alu_src_b  (ALUSrcB),
    .result_src (ResultSrc),
    .imm_src    (dec_imm_src),
    .alu_op     (ALU_op)
  );

  assign PCWrite = dec_pc_write & ((dec_state != S_FETCH) | ready);
  assign IRWrite = dec_ir_write & ready;
  assign ImmSrc  = dec_imm_src
                 | {1'b0, (dec_state == S_MEMADR) && (opcode == OP_STORE)};
  assign illegal = illegal_q;

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:    if (ready) next_state = S_DECODE;
      S_DECODE: begin
        if (is_mem_op(opcode))        next_state = S_MEMADR;
        else if (opcode == OP_R)      next_state = S_EXEC_R;
        else if (opcode == OP_I)      next_state = S_EXEC_I;
        else if (opcode == OP_BRANCH) next_state = S_BRANCH;
        else if (opcode == OP_JAL)    next_state = S_JAL;
        else if (opcode == OP_LUI)    next_state = S_LUI;
        else                          next_state = S_TRAP;
      end
      S_MEMADR:   next_state = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (ready) next_state = S_MEMWB;
      S_MEMWRITE: if (ready) next_state = S_FETCH;
      S_EXEC_R,
      S_EXEC_I:   next_state = S_ALUWB;
      S_TRAP:     next_state = S_TRAP;
      default:    next_state = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state     <= S_FETCH;
      active    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state     <= next_state;
      active    <= 1'b1;
      illegal_q <= illegal_q | (next_state == S_TRAP);
    end
  end

endmodule
